ibex_load_resp_unit: RTL and testbench
======================================

Name: ibex_load_resp_unit

Overview:
- Data-side response end of the load/store writeback interface.
- Tracks issued data-memory transactions and consumes data-bus responses (single-beat, misaligned two-beat, capability two-beat).
- Aligns, sign-extends and assembles the load result.
- Drives the LSU write port and response strobes consumed by the writeback stage (rf_*_lsu, lsu_resp_valid, lsu_resp_err).

Parameters:
- CheriCapWidth, 91, width of the capability write-data output; must be ≥ MemCapWidth.
- MemCapWidth, 65, memory-format capability width: {tag, hi word, lo word}.
- PendDepth, 2, descriptor FIFO depth (outstanding transactions); power of two, ≥ 2.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- issue_valid_i  in  1  LSU has issued a bus transaction for an instruction
- issue_ready_o  out  1  descriptor FIFO not full
- issue_desc_i  in  8  load_desc_t: is_load, is_cap, size[1:0] (byte/half/word), sign_ext, offset[1:0], two_beat
- data_rvalid_i  in  1  bus response beat valid
- data_rdata_i  in  32  response data
- data_rtag_i  in  1  tag bit accompanying the beat
- data_err_i  in  1  bus error on the beat
- rf_we_lsu_o  out  1  load result write enable
- rf_wcap_lsu_o  out  1  write is a capability
- rf_wdata_int_lsu_o  out  32  integer load result
- rf_wdata_cap_lsu_o  out  CheriCapWidth  capability load result: memory format in [MemCapWidth-1:0], upper bits zero
- lsu_resp_valid_o  out  1  instruction's final beat received (load or store)
- lsu_resp_err_o  out  1  error on any beat of the instruction
- pend_empty_o  out  1  no outstanding descriptors

Behaviour:
- While rst_i is high:
  - FIFO empties; FSM goes to IDLE; holding registers clear.
  - All outputs are 0, except issue_ready_o = 0 and pend_empty_o = 1.
- FIFO push: issue_valid_i & issue_ready_o. Pop: the final beat of the head descriptor.
  - Push and pop in the same cycle when full: the pop is taken first, but issue_ready_o remains the registered !full, so the push is not accepted.
  - Pointers wrap modulo PendDepth.
- FSM states:
  - IDLE: waiting for the first beat of the head descriptor.
  - SECOND: head is two_beat and the first beat has been captured.
  - IDLE→SECOND on data_rvalid_i when head.two_beat. SECOND→IDLE on data_rvalid_i.
- First beat of a two-beat transaction: latch rdata into lo_q, rtag into tag_q, err into err_q. No outputs.
- Final beat (data_rvalid_i in IDLE with !two_beat, or in SECOND) is zero latency; all outputs are combinational in that cycle:
  - lsu_resp_valid_o = 1.
  - lsu_resp_err_o = err_q | data_err_i (err_q is 0 for single-beat).
  - rf_we_lsu_o = head.is_load & !lsu_resp_err_o.
  - rf_wcap_lsu_o = rf_we_lsu_o & head.is_cap.
- Integer result (is_cap = 0), beats combined as {rdata, lo_q}:
  - Byte: byte at offset, sign/zero extended.
  - Half: 16 bits at offset; offset 3 spans beats.
  - Word: 32 bits at offset; offset ≠ 0 spans beats.
  - Example: word at offset 1 = {rdata[7:0], lo_q[31:8]}.
- Capability result: {tag_q & data_rtag_i, rdata, lo_q}.
  - Tag is cleared on any error.
  - rf_wdata_int_lsu_o = lo_q in this case.
- Error outputs: rf_wdata_* are driven 0 when rf_we_lsu_o = 0.
- data_rvalid_i with an empty FIFO: ignored, no outputs; flagged by assertion.
- Stores (is_load = 0): only the response strobes; two-beat misaligned stores are supported.
- Assertions:
  - at most one of rf_we_lsu_o/resp per cycle;
  - never SECOND with an empty FIFO;
  - rf_wcap_lsu_o implies rf_we_lsu_o.

Decomposition:
- ibex_pkg: load_desc_t packed struct; size encodings (LS_BYTE = 0, LS_HALF = 1, LS_WORD = 2); lr_state_e {LR_IDLE, LR_SECOND}.
- One sub-module: ibex_load_resp_fifo, the parameterised descriptor FIFO with count/full/empty.
- Alignment and extension logic is a package function, load_align(desc, hi, lo).

Test Plan:
- Reset mid-SECOND: issue two-beat word (offset 2), one beat, assert rst_i → pend_empty_o = 1, no resp on the next beat.
- Signed byte, offset 3, rdata = 0x80AABBCC → single cycle: resp_valid = 1, we = 1, wdata_int = 0xFFFFFF80.
- Misaligned word offset 1: beats 0x44332211 then 0x88776655 → resp on the second beat only, wdata_int = 0x55443322.
- Cap load:
  - beats (0xDEADBEEF, tag 1), (0x01234567, tag 1) → wcap = 1, cap[64:0] = {1, 0x01234567, 0xDEADBEEF}.
  - Repeat with err on the first beat → resp_err = 1, we = 0, wdata_cap = 0.
- Back-to-back: issue load and store, FIFO full (issue_ready_o = 0); responses on consecutive cycles → two resp_valid pulses, we only on the first; issue_ready_o high again.
- Unsolicited data_rvalid_i with empty FIFO → all outputs 0; assertion fires in negative test.

Source files
------------

// File: rtl/ibex_pkg.sv
// Shared types and the load alignment helper for the LSU response path.
package ibex_pkg;

  localparam logic [1:0] LS_BYTE = 2'd0;
  localparam logic [1:0] LS_HALF = 2'd1;
  localparam logic [1:0] LS_WORD = 2'd2;

  typedef struct packed {
    logic       is_load;
    logic       is_cap;
    logic [1:0] size;
    logic       sign_ext;
    logic [1:0] offset;
    logic       two_beat;
  } load_desc_t;

  typedef enum logic [0:0] {
    LR_IDLE   = 1'b0,
    LR_SECOND = 1'b1
  } lr_state_e;

  // Single-beat data sits in hi alone; two-beat data is {hi, lo} with the offset into lo.
  function automatic logic [31:0] load_align(load_desc_t desc, logic [31:0] hi, logic [31:0] lo);
    logic [63:0] beats;
    logic [31:0] shifted;
    logic [31:0] res;
    if (!desc.is_load) begin
      res = 32'h0;
    end else if (desc.is_cap) begin
      res = lo;
    end else begin
      beats   = desc.two_beat ? {hi, lo} : {32'h0, hi};
      shifted = 32'(beats >> {desc.offset, 3'b000});
      case (desc.size)
        LS_BYTE: res = {{24{desc.sign_ext & shifted[7]}}, shifted[7:0]};
        LS_HALF: res = {{16{desc.sign_ext & shifted[15]}}, shifted[15:0]};
        LS_WORD: res = shifted;
        default: res = shifted;
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/ibex_load_resp_unit_chk.sv
// Protocol checks for the load response unit.
module ibex_load_resp_unit_chk (
  input logic clk_i,
  input logic rst_i,
  input logic rf_we,
  input logic rf_wcap,
  input logic resp_valid,
  input logic in_second,
  input logic pend_empty,
  input logic rvalid,
  input logic push,
  input logic full
);

  a_we_resp: assert property (@(posedge clk_i) disable iff (rst_i) rf_we |-> resp_valid)
    else $error("register write without a response");
  a_wcap_we: assert property (@(posedge clk_i) disable iff (rst_i) rf_wcap |-> rf_we)
    else $error("capability write without register write");
  a_second_pend: assert property (@(posedge clk_i) disable iff (rst_i) in_second |-> !pend_empty)
    else $error("second-beat state with no outstanding descriptor");
  a_push_full: assert property (@(posedge clk_i) disable iff (rst_i) push |-> !full)
    else $error("descriptor accepted while full");
  a_unsolicited: assert property (@(posedge clk_i) disable iff (rst_i) rvalid |-> !pend_empty)
    else $warning("data response with no outstanding transaction");

endmodule

// File: rtl/ibex_load_resp_unit_fifo.sv
// Descriptor FIFO for outstanding data-memory transactions; ready is a registered !full.
module ibex_load_resp_fifo
  import ibex_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  load_desc_t push_desc_i,
  input  logic       pop_i,
  output load_desc_t head_o,
  output logic       ready_o,
  output logic       empty_o,
  output logic       full_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  load_desc_t      mem_r [Depth];
  logic [PtrW-1:0] wr_ptr_r;
  logic [PtrW-1:0] rd_ptr_r;
  logic [CntW-1:0] count_r;
  logic [CntW-1:0] count_next_s;
  logic            ready_r;
  logic            push_s;
  logic            pop_s;

  assign push_s  = push_i & ready_r;
  assign pop_s   = pop_i & ~empty_o;
  assign empty_o = (count_r == {CntW{1'b0}});
  assign full_o  = (count_r == DepthCnt);
  assign ready_o = ready_r;
  assign head_o  = mem_r[rd_ptr_r];

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CntW'(1);
      2'b01:   count_next_s = count_r - CntW'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Pointers, count and the registered ready flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_r <= {PtrW{1'b0}};
      rd_ptr_r <= {PtrW{1'b0}};
      count_r  <= {CntW{1'b0}};
      ready_r  <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PtrW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PtrW'(1);
      count_r <= count_next_s;
      ready_r <= (count_next_s != DepthCnt);
    end
  end

  // Descriptor storage; contents are only read while non-empty.
  always_ff @(posedge clk_i) begin
    if (push_s) mem_r[wr_ptr_r] <= push_desc_i;
  end

endmodule

// File: rtl/ibex_load_resp_unit.sv
// LSU response end: tracks issued transactions, assembles load results and drives the writeback port.
module ibex_load_resp_unit
  import ibex_pkg::*;
#(
  parameter int unsigned CheriCapWidth = 91,
  parameter int unsigned MemCapWidth   = 65,
  parameter int unsigned PendDepth     = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     issue_valid_i,
  output logic                     issue_ready_o,
  input  load_desc_t               issue_desc_i,
  input  logic                     data_rvalid_i,
  input  logic [31:0]              data_rdata_i,
  input  logic                     data_rtag_i,
  input  logic                     data_err_i,
  output logic                     rf_we_lsu_o,
  output logic                     rf_wcap_lsu_o,
  output logic [31:0]              rf_wdata_int_lsu_o,
  output logic [CheriCapWidth-1:0] rf_wdata_cap_lsu_o,
  output logic                     lsu_resp_valid_o,
  output logic                     lsu_resp_err_o,
  output logic                     pend_empty_o
);

  load_desc_t             head_s;
  logic                   empty_s;
  logic                   full_s;
  logic                   push_s;
  logic                   beat_s;
  logic                   first_s;
  logic                   final_s;
  logic                   err_s;
  logic [MemCapWidth-1:0] mem_cap_s;
  lr_state_e              state_r;
  lr_state_e              state_next_s;
  logic [31:0]            lo_r;
  logic                   tag_r;
  logic                   err_r;

  assign push_s       = issue_valid_i & issue_ready_o;
  assign pend_empty_o = empty_s;

  ibex_load_resp_fifo #(
    .Depth (PendDepth)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (issue_valid_i),
    .push_desc_i (issue_desc_i),
    .pop_i       (final_s),
    .head_o      (head_s),
    .ready_o     (issue_ready_o),
    .empty_o     (empty_s),
    .full_o      (full_s)
  );

  // Beats arriving with nothing outstanding are dropped here.
  assign beat_s    = data_rvalid_i & ~empty_s & ~rst_i;
  assign first_s   = beat_s & (state_r == LR_IDLE) & head_s.two_beat;
  assign final_s   = beat_s & ((state_r == LR_SECOND) | ~head_s.two_beat);
  assign err_s     = final_s & (((state_r == LR_SECOND) & err_r) | data_err_i);
  assign mem_cap_s = MemCapWidth'({tag_r & data_rtag_i & ~err_s, data_rdata_i, lo_r});

  // Beat-sequencing next state.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      LR_IDLE: begin
        if (first_s) state_next_s = LR_SECOND;
        else         state_next_s = LR_IDLE;
      end
      LR_SECOND: begin
        if (beat_s) state_next_s = LR_IDLE;
        else        state_next_s = LR_SECOND;
      end
      default: state_next_s = LR_IDLE;
    endcase
  end

  // State and first-beat holding registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= LR_IDLE;
      lo_r    <= 32'h0;
      tag_r   <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (first_s) begin
        lo_r  <= data_rdata_i;
        tag_r <= data_rtag_i;
        err_r <= data_err_i;
      end
    end
  end

  // Zero-latency response and write port on the final beat.
  always_comb begin
    lsu_resp_valid_o   = final_s;
    lsu_resp_err_o     = err_s;
    rf_we_lsu_o        = 1'b0;
    rf_wcap_lsu_o      = 1'b0;
    rf_wdata_int_lsu_o = 32'h0;
    rf_wdata_cap_lsu_o = {CheriCapWidth{1'b0}};
    if (final_s & head_s.is_load & ~err_s) begin
      rf_we_lsu_o        = 1'b1;
      rf_wcap_lsu_o      = head_s.is_cap;
      rf_wdata_int_lsu_o = load_align(head_s, data_rdata_i, lo_r);
      if (head_s.is_cap) rf_wdata_cap_lsu_o = CheriCapWidth'(mem_cap_s);
      else               rf_wdata_cap_lsu_o = {CheriCapWidth{1'b0}};
    end else begin
      rf_we_lsu_o        = 1'b0;
      rf_wdata_cap_lsu_o = {CheriCapWidth{1'b0}};
    end
  end

  ibex_load_resp_unit_chk u_chk (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rf_we      (rf_we_lsu_o),
    .rf_wcap    (rf_wcap_lsu_o),
    .resp_valid (lsu_resp_valid_o),
    .in_second  (state_r == LR_SECOND),
    .pend_empty (empty_s),
    .rvalid     (data_rvalid_i),
    .push       (push_s),
    .full       (full_s)
  );

endmodule

// File: tb/tb_ibex_load_resp_unit.sv
// Self-checking bench for ibex_load_resp_unit: directed scenarios plus randomized traffic vs a byte-level model.
module tb_ibex_load_resp_unit;
  import ibex_pkg::*;

  localparam int unsigned CapW = 91;

  logic            clk = 1'b0;
  logic            rst_i = 1'b1;
  logic            issue_valid = 1'b0;
  logic            issue_ready;
  load_desc_t      issue_desc = '0;
  logic            data_rvalid = 1'b0;
  logic [31:0]     data_rdata = 32'h0;
  logic            data_rtag = 1'b0;
  logic            data_err = 1'b0;
  logic            rf_we, rf_wcap, resp_valid, resp_err, pend_empty;
  logic [31:0]     wdata_int;
  logic [CapW-1:0] wdata_cap;

  int checks = 0;
  int errors = 0;

  logic            o_valid, o_err, o_we, o_wcap;
  logic [31:0]     o_int;
  logic [CapW-1:0] o_cap;

  always #5 clk = ~clk;

  ibex_load_resp_unit #(.CheriCapWidth(CapW), .MemCapWidth(65), .PendDepth(2)) dut (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .issue_valid_i      (issue_valid),
    .issue_ready_o      (issue_ready),
    .issue_desc_i       (issue_desc),
    .data_rvalid_i      (data_rvalid),
    .data_rdata_i       (data_rdata),
    .data_rtag_i        (data_rtag),
    .data_err_i         (data_err),
    .rf_we_lsu_o        (rf_we),
    .rf_wcap_lsu_o      (rf_wcap),
    .rf_wdata_int_lsu_o (wdata_int),
    .rf_wdata_cap_lsu_o (wdata_cap),
    .lsu_resp_valid_o   (resp_valid),
    .lsu_resp_err_o     (resp_err),
    .pend_empty_o       (pend_empty)
  );

  // Reference: pick bytes out of the beat stream, mask to size, sign-extend arithmetically.
  function automatic logic [31:0] model_int(load_desc_t d, logic [31:0] b1, logic [31:0] b2);
    logic [63:0] stream, mask, val;
    int nbytes;
    if (!d.is_load) return 32'h0;
    if (d.is_cap) return b1;
    stream = d.two_beat ? {b2, b1} : {32'h0, b1};
    nbytes = 1 << d.size;
    mask   = (64'h1 << (8 * nbytes)) - 64'h1;
    val    = (stream >> (8 * d.offset)) & mask;
    if (d.sign_ext && val[8 * nbytes - 1]) val = val | ~mask;
    return val[31:0];
  endfunction

  function automatic load_desc_t mk(logic ld, logic cap, logic [1:0] sz, logic sx, logic [1:0] off);
    load_desc_t d;
    d.is_load  = ld;
    d.is_cap   = cap;
    d.size     = sz;
    d.sign_ext = sx;
    d.offset   = off;
    d.two_beat = cap ? 1'b1 : ((int'(off) + (1 << sz)) > 4);
    return d;
  endfunction

  // All tasks start and end at posedge+1 with inputs idle.
  task automatic do_issue(input load_desc_t d);
    int n = 0;
    while (!issue_ready && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (issue_ready !== 1'b1) begin errors++; $display("FAIL issue_ready_timeout: got %b want 1", issue_ready); end
    issue_valid = 1'b1;
    issue_desc  = d;
    @(posedge clk); #1;
    issue_valid = 1'b0;
  endtask

  task automatic do_beat(input logic [31:0] d, input logic t, input logic e);
    data_rvalid = 1'b1; data_rdata = d; data_rtag = t; data_err = e;
    @(negedge clk);
    o_valid = resp_valid; o_err = resp_err; o_we = rf_we; o_wcap = rf_wcap;
    o_int = wdata_int; o_cap = wdata_cap;
    @(posedge clk); #1;
    data_rvalid = 1'b0; data_rdata = 32'h0; data_rtag = 1'b0; data_err = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; data_rvalid = 1'b1; data_rdata = 32'hFFFF_FFFF; data_rtag = 1'b1;
    issue_valid = 1'b1; issue_desc = mk(1'b1, 1'b0, LS_WORD, 1'b0, 2'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", issue_ready); end
    checks++; if (pend_empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b want 1", pend_empty); end
    checks++; if ({resp_valid, resp_err, rf_we, rf_wcap} !== 4'b0) begin errors++; $display("FAIL rst_strobes: got %b want 0000", {resp_valid, resp_err, rf_we, rf_wcap}); end
    checks++; if (wdata_int !== 32'h0 || wdata_cap !== '0) begin errors++; $display("FAIL rst_wdata: got %h/%h want 0", wdata_int, wdata_cap); end
    @(posedge clk); #1;
    rst_i = 1'b0; data_rvalid = 1'b0; data_rdata = 32'h0; data_rtag = 1'b0; issue_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b want 1", issue_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_second();
    do_issue(mk(1'b1, 1'b0, LS_WORD, 1'b0, 2'd2));
    do_beat(32'h1122_3344, 1'b0, 1'b0);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL midrst_first_beat: got %b want 0", o_valid); end
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    checks++; if (pend_empty !== 1'b1) begin errors++; $display("FAIL midrst_empty: got %b want 1", pend_empty); end
    @(posedge clk); #1;
    do_beat(32'h5566_7788, 1'b0, 1'b0);
    checks++; if ({o_valid, o_we} !== 2'b00) begin errors++; $display("FAIL midrst_no_resp: got %b want 00", {o_valid, o_we}); end
  endtask

  task automatic test_signed_byte();
    do_issue(mk(1'b1, 1'b0, LS_BYTE, 1'b1, 2'd3));
    do_beat(32'h80AA_BBCC, 1'b0, 1'b0);
    checks++; if ({o_valid, o_we, o_err, o_wcap} !== 4'b1100) begin errors++; $display("FAIL sbyte_strobes: got %b want 1100", {o_valid, o_we, o_err, o_wcap}); end
    checks++; if (o_int !== 32'hFFFF_FF80) begin errors++; $display("FAIL sbyte_data: got %h want ffffff80", o_int); end
  endtask

  task automatic test_misaligned_word();
    do_issue(mk(1'b1, 1'b0, LS_WORD, 1'b0, 2'd1));
    do_beat(32'h4433_2211, 1'b0, 1'b0);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL misw_first: got %b want 0", o_valid); end
    do_beat(32'h8877_6655, 1'b0, 1'b0);
    checks++; if ({o_valid, o_we} !== 2'b11) begin errors++; $display("FAIL misw_strobes: got %b want 11", {o_valid, o_we}); end
    checks++; if (o_int !== 32'h5544_3322) begin errors++; $display("FAIL misw_data: got %h want 55443322", o_int); end
  endtask

  task automatic test_cap();
    logic [CapW-1:0] exp_cap;
    exp_cap = '0;
    exp_cap[64:0] = {1'b1, 32'h0123_4567, 32'hDEAD_BEEF};
    do_issue(mk(1'b1, 1'b1, LS_WORD, 1'b0, 2'd0));
    do_beat(32'hDEAD_BEEF, 1'b1, 1'b0);
    do_beat(32'h0123_4567, 1'b1, 1'b0);
    checks++; if ({o_valid, o_we, o_wcap, o_err} !== 4'b1110) begin errors++; $display("FAIL cap_strobes: got %b want 1110", {o_valid, o_we, o_wcap, o_err}); end
    checks++; if (o_cap !== exp_cap) begin errors++; $display("FAIL cap_data: got %h want %h", o_cap, exp_cap); end
    checks++; if (o_int !== 32'hDEAD_BEEF) begin errors++; $display("FAIL cap_int: got %h want deadbeef", o_int); end
    do_issue(mk(1'b1, 1'b1, LS_WORD, 1'b0, 2'd0));
    do_beat(32'hDEAD_BEEF, 1'b1, 1'b1);
    do_beat(32'h0123_4567, 1'b1, 1'b0);
    checks++; if ({o_valid, o_err, o_we, o_wcap} !== 4'b1100) begin errors++; $display("FAIL caperr_strobes: got %b want 1100", {o_valid, o_err, o_we, o_wcap}); end
    checks++; if (o_cap !== '0 || o_int !== 32'h0) begin errors++; $display("FAIL caperr_data: got %h/%h want 0", o_cap, o_int); end
  endtask

  task automatic test_back_to_back();
    do_issue(mk(1'b1, 1'b0, LS_BYTE, 1'b0, 2'd0));
    do_issue(mk(1'b0, 1'b0, LS_WORD, 1'b0, 2'd0));
    @(negedge clk);
    checks++; if ({issue_ready, pend_empty} !== 2'b00) begin errors++; $display("FAIL b2b_full: got %b want 00", {issue_ready, pend_empty}); end
    @(posedge clk); #1;
    issue_valid = 1'b1; issue_desc = mk(1'b1, 1'b0, LS_WORD, 1'b0, 2'd0);
    do_beat(32'h1234_56A5, 1'b0, 1'b0);
    issue_valid = 1'b0;
    checks++; if ({o_valid, o_we, o_int} !== {2'b11, 32'h0000_00A5}) begin errors++; $display("FAIL b2b_load: got %b%b %h want 11 000000a5", o_valid, o_we, o_int); end
    do_beat(32'h1111_1111, 1'b0, 1'b0);
    checks++; if ({o_valid, o_we, o_err, o_int} !== {3'b100, 32'h0}) begin errors++; $display("FAIL b2b_store: got %b%b%b %h want 100 0", o_valid, o_we, o_err, o_int); end
    @(negedge clk);
    checks++; if ({issue_ready, pend_empty} !== 2'b11) begin errors++; $display("FAIL b2b_drained: got %b want 11", {issue_ready, pend_empty}); end
    @(posedge clk); #1;
  endtask

  task automatic test_unsolicited();
    do_beat(32'hCAFE_F00D, 1'b1, 1'b1);
    checks++; if ({o_valid, o_err, o_we, o_wcap} !== 4'b0 || o_int !== 32'h0 || o_cap !== '0) begin
      errors++; $display("FAIL unsolicited: got %b %h %h want all 0", {o_valid, o_err, o_we, o_wcap}, o_int, o_cap); end
    @(negedge clk);
    checks++; if (pend_empty !== 1'b1) begin errors++; $display("FAIL unsolicited_empty: got %b want 1", pend_empty); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    load_desc_t q[$];
    load_desc_t d;
    logic [31:0] b1, b2, exp_int;
    logic t1, t2, e1, e2, exp_err, exp_we;
    logic [CapW-1:0] exp_cap;
    int k, gap;
    for (int it = 0; it < 80; it++) begin
      k = $urandom_range(1, 2);
      for (int j = 0; j < k; j++) begin
        if ($urandom_range(0, 3) == 0) d = mk(1'($urandom_range(0, 1)), 1'b1, LS_WORD, 1'b0, 2'd0);
        else d = mk(1'($urandom_range(0, 1)), 1'b0, 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        do_issue(d);
        q.push_back(d);
      end
      while (q.size() > 0) begin
        d = q.pop_front();
        b1 = $urandom; t1 = 1'($urandom_range(0, 1)); e1 = ($urandom_range(0, 7) == 0);
        b2 = $urandom; t2 = 1'($urandom_range(0, 1)); e2 = ($urandom_range(0, 7) == 0);
        if (d.two_beat) begin
          do_beat(b1, t1, e1);
          checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rnd_first_beat it%0d: got %b want 0", it, o_valid); end
          gap = $urandom_range(0, 2);
          repeat (gap) begin @(posedge clk); #1; end
          do_beat(b2, t2, e2);
          exp_err = e1 | e2;
        end else begin
          do_beat(b1, t1, e1);
          exp_err = e1;
        end
        exp_we  = d.is_load & ~exp_err;
        exp_int = exp_we ? model_int(d, b1, b2) : 32'h0;
        exp_cap = (exp_we && d.is_cap) ? CapW'({t1 & t2, b2, b1}) : '0;
        checks++;
        if ({o_valid, o_err, o_we, o_wcap} !== {1'b1, exp_err, exp_we, exp_we & d.is_cap} || o_int !== exp_int || o_cap !== exp_cap) begin
          errors++;
          $display("FAIL rnd_resp it%0d desc %h: got %b %h %h want %b %h %h", it, d,
                   {o_valid, o_err, o_we, o_wcap}, o_int, o_cap,
                   {1'b1, exp_err, exp_we, exp_we & d.is_cap}, exp_int, exp_cap);
        end
      end
    end
    @(negedge clk);
    checks++; if (pend_empty !== 1'b1) begin errors++; $display("FAIL rnd_drained: got %b want 1", pend_empty); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_reset_mid_second();
    test_signed_byte();
    test_misaligned_word();
    test_cap();
    test_back_to_back();
    test_unsolicited();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
